// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  function automatic int len_w(input int pattern_w);
    return $clog2(pattern_w + 1);
  endfunction

  // Holds at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter; only instantiated when SEQDET_MATCH_CNT_EN is defined.
module seq_det_match_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with Mealy match strobe z.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W   = 8,
  parameter logic [PATTERN_W-1:0] DEFAULT_PAT = 8'h0A,
  parameter int                   DEFAULT_LEN = 4,
  parameter int                   DEFAULT_OVL = 1,
  parameter int                   CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          w,
  input  logic                          w_valid,
  input  logic                          cfg_load,
  input  logic [PATTERN_W-1:0]          cfg_pattern,
  input  logic [len_w(PATTERN_W)-1:0]   cfg_len,
  input  logic                          cfg_overlap,
  output logic                          z,
  output logic                          z_r,
  output logic [CNT_W-1:0]              match_cnt
);

  localparam int LEN_W = len_w(PATTERN_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PATTERN_W);

  logic [PATTERN_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]     fill_q, fill_d;
  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 ovl_q, ovl_d;
  logic                 z_r_q;

  logic [LEN_W-1:0]     cfg_len_c;
  logic [LEN_W-1:0]     fill_inc;
  logic [PATTERN_W:0]   window;
  logic [PATTERN_W:0]   win_mask;
  logic                 match;

  always_comb begin
    cfg_len_c = cfg_len;
    if (cfg_len == '0) begin
      cfg_len_c = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      cfg_len_c = LEN_MAX;
    end
  end

  // Window includes the incoming bit; the top bit is never part of a match.
  always_comb begin
    window = {hist_q, w};
    for (int i = 0; i <= PATTERN_W; i++) begin
      win_mask[i] = (i < int'(len_q));
    end
    match = w_valid & ~cfg_load & (fill_q >= (len_q - LEN_W'(1))) &
            (((window ^ {1'b0, pattern_q}) & win_mask) == '0);
    fill_inc = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
  end

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    if (cfg_load) begin
      hist_d    = '0;
      fill_d    = '0;
      pattern_d = cfg_pattern;
      len_d     = cfg_len_c;
      ovl_d     = cfg_overlap;
    end else if (w_valid) begin
      hist_d = window[PATTERN_W-1:0];
      fill_d = (match && (ovl_q == OVL_OFF)) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEFAULT_PAT;
      len_q     <= LEN_W'(DEFAULT_LEN);
      ovl_q     <= (DEFAULT_OVL != 0);
      z_r_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      z_r_q     <= z;
    end
  end

  assign z   = match & resetn;
  assign z_r = z_r_q;

`ifdef SEQDET_MATCH_CNT_EN
  seq_det_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cfg_load),
    .inc    (match),
    .cnt    (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; expected counts follow SEQDET_MATCH_CNT_EN.
module tb_seq_detector_param;

`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       w = 1'b0;
  logic       w_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len = 4'd0;
  logic       cfg_overlap = 1'b0;

  logic       z_a, z_r_a, z_b, z_r_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  seq_detector_param u_dut_a (
    .clk(clk), .resetn(resetn), .w(w), .w_valid(w_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z_a), .z_r(z_r_a), .match_cnt(cnt_a)
  );

  seq_detector_param #(.CNT_W(2)) u_dut_b (
    .clk(clk), .resetn(resetn), .w(w), .w_valid(w_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z_b), .z_r(z_r_b), .match_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_sat(input int cnt, input int max_val);
    if (!CNT_EN) return 32'd0;
    return 32'((cnt > max_val) ? max_val : cnt);
  endfunction

  task automatic check_cnt(input string tag);
    check({tag, ".cnt_a"}, 32'(cnt_a), exp_sat(exp_cnt, 255));
    check({tag, ".cnt_b"}, 32'(cnt_b), exp_sat(exp_cnt, 3));
  endtask

  // One serial bit: z checked mid-cycle, z_r and counters after the edge.
  task automatic step(input string tag, input logic wi, input logic vi, input logic ze);
    @(negedge clk);
    w = wi;
    w_valid = vi;
    #1;
    check({tag, ".z_a"}, 32'(z_a), 32'(ze));
    check({tag, ".z_b"}, 32'(z_b), 32'(ze));
    if (ze) exp_cnt++;
    @(posedge clk);
    #1;
    check({tag, ".z_r"}, 32'(z_r_a), 32'(ze));
    check_cnt(tag);
  endtask

  // Load with a would-match valid bit present to exercise load priority.
  task automatic load(input string tag, input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_pattern = pat;
    cfg_len = len;
    cfg_overlap = ovl;
    w = pat[0];
    w_valid = 1'b1;
    #1;
    check({tag, ".load_z"}, 32'(z_a), 32'd0);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    cfg_pattern = ~pat;
    cfg_len = 4'd2;
    cfg_overlap = ~ovl;
    w_valid = 1'b0;
    exp_cnt = 0;
    check({tag, ".load_zr"}, 32'(z_r_a), 32'd0);
    check_cnt({tag, ".load"});
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    w_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    #2;
    check("rst.z", 32'(z_a), 32'd0);
    check("rst.z_r", 32'(z_r_a), 32'd0);
    check("rst.cnt_a", 32'(cnt_a), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Default 1010, overlap: z on bits 4 and 6
    step("t1.b1", 1, 1, 0);
    step("t1.b2", 0, 1, 0);
    step("t1.b3", 1, 1, 0);
    step("t1.b4", 0, 1, 1);
    step("t1.b5", 1, 1, 0);
    step("t1.b6", 0, 1, 1);

    // 110 non-overlap; cfg inputs scrambled after load
    load("t2", 8'b110, 4'd3, 1'b0);
    step("t2.b1", 1, 1, 0);
    step("t2.b2", 1, 1, 0);
    step("t2.b3", 0, 1, 1);
    step("t2.b4", 1, 1, 0);
    step("t2.b5", 1, 1, 0);
    step("t2.b6", 0, 1, 1);

    load("t3o", 8'b111, 4'd3, 1'b1);
    for (int i = 1; i <= 5; i++) step("t3o.b", 1, 1, i >= 3);
    load("t3n", 8'b111, 4'd3, 1'b0);
    for (int i = 1; i <= 5; i++) step("t3n.b", 1, 1, i == 3);

    // Gap in w_valid holds history
    do_reset();
    step("t4.b1", 1, 1, 0);
    step("t4.b2", 0, 1, 0);
    step("t4.b3", 1, 1, 0);
    for (int i = 0; i < 3; i++) step("t4.gap", 0, 0, 0);
    step("t4.b4", 0, 1, 1);

    // Reset mid-sequence
    do_reset();
    step("t5.b1", 1, 1, 0);
    step("t5.b2", 0, 1, 0);
    step("t5.b3", 1, 1, 0);
    @(negedge clk);
    w = 1'b0;
    w_valid = 1'b1;
    #1;
    check("t5.pre_z", 32'(z_a), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("t5.rst_z", 32'(z_a), 32'd0);
    check("t5.rst_zr", 32'(z_r_a), 32'd0);
    check("t5.rst_cnt", 32'(cnt_a), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    exp_cnt = 0;
    #1;
    check("t5.post_z", 32'(z_a), 32'd0);
    @(posedge clk);
    #1;
    check("t5.post_zr", 32'(z_r_a), 32'd0);

    // len=1 pattern 1: counter runs 1..6, the 2-bit one saturates at 3
    load("t6", 8'h01, 4'd1, 1'b1);
    for (int i = 1; i <= 6; i++) step("t6.b", 1, 1, 1);
    check("t6.sat_b", 32'(cnt_b), CNT_EN ? 32'd3 : 32'd0);
    check("t6.full_a", 32'(cnt_a), CNT_EN ? 32'd6 : 32'd0);
    load("t6c", 8'h01, 4'd1, 1'b1);

    // len=0 treated as 1
    load("t7", 8'h01, 4'd0, 1'b1);
    step("t7.b1", 0, 1, 0);
    step("t7.b2", 1, 1, 1);

    // len=15 clamped to 8
    load("t8", 8'hFF, 4'd15, 1'b1);
    for (int i = 1; i <= 9; i++) step("t8.b", 1, 1, i >= 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
